regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter MP_DATA_WIDTH SHALL default to 32 and set the write-data width.
REQ-003 Parameter MP_ADDR_WIDTH SHALL default to 5 and set the register-address width (2**MP_ADDR_WIDTH registers).
REQ-004 iclk  input  1  clock; all state updates on the rising edge.
REQ-005 irst  input  1  asynchronous active-high reset.
REQ-006 ivalid0  input  1  requester 0 (pipeline writeback) has a write pending.
REQ-007 ia0 / iwdata0  input  MP_ADDR_WIDTH / MP_DATA_WIDTH  requester 0 destination address and data.
REQ-008 oready0  output  1  requester 0 write accepted this cycle.
REQ-009 ivalid1, ia1, iwdata1, oready1  SHALL be the same ports, with the same widths, for requester 1 (long-latency unit).
REQ-010 owen3  output  1  register-file write enable.
REQ-011 oa3 / owdata3  output  MP_ADDR_WIDTH / MP_DATA_WIDTH  register-file write address and data.
REQ-012 ireserve  input  1  reserve the destination register ireserve_a for a future write.
REQ-013 ireserve_a  input  MP_ADDR_WIDTH  address to reserve.
REQ-014 irs1 / irs2  input  MP_ADDR_WIDTH  source addresses to check.
REQ-015 ohazard  output  1  irs1 or irs2 is busy (combinational).
REQ-016 obusy  output  2**MP_ADDR_WIDTH  scoreboard bitmap.

Function
REQ-017 A transfer on port n SHALL occur when ivalid_n and oready_n are both high in the same cycle.
REQ-018 oready_n SHALL be combinational; at most one of oready0 and oready1 SHALL be high in any cycle.
REQ-019 Grant with only one ivalid high: that port is granted.
REQ-020 Grant with neither ivalid high: no port is granted.
REQ-021 Grant with both ivalid high: the port not granted on the most recent transfer wins (round-robin).
REQ-022 The last-grant register (rlast) SHALL update only on a transfer.
REQ-023 A requester holding ivalid SHALL be granted within 2 cycles.
REQ-024 The write output stage SHALL be registered with 1-cycle latency: a transfer in cycle t drives owen3, oa3 and owdata3 in cycle t+1.
REQ-025 A transfer with address 0 SHALL be accepted (oready high) but SHALL NOT assert owen3.
REQ-026 owen3 SHALL be low in any cycle following a cycle with no transfer.
REQ-027 oa3 and owdata3 SHALL hold their last values when owen3 is low.
REQ-028 Back-to-back transfers SHALL produce one owen3 pulse per cycle, in grant order.

Reset
REQ-029 While irst is high, all of the following SHALL hold: owen3=0, oa3=0, owdata3=0, obusy=0, rlast=1 (port 0 wins the first contention); oready0 and oready1 follow REQ-018 to REQ-021.
REQ-030 Reset asserted mid-operation SHALL drop any write registered but not yet presented; the lost write is not retried.
REQ-031 After reset is released, the first clock edge SHALL behave as a normal cycle.

Configuration
REQ-032 Macro RF_ARB_SCOREBOARD_EN SHALL enable the scoreboard.
REQ-033 With the macro defined, an ireserve with address != 0 SHALL set obusy[ireserve_a] at the clock edge.
REQ-034 With the macro defined, any transfer to address a SHALL clear obusy[a] at the same edge.
REQ-035 With the macro defined, if a set and a clear target the same address in the same cycle, the set SHALL win.
REQ-036 With the macro defined, obusy[0] SHALL always be 0, and ohazard = obusy[irs1] | obusy[irs2].
REQ-037 With the macro undefined, obusy and ohazard SHALL be constant 0, ireserve and ireserve_a SHALL be ignored, and the arbitration behaviour SHALL be identical to the macro-defined build.

Verification
REQ-038 Single requester: ivalid0=1, ia0=5, iwdata0=0xDEADBEEF for 1 cycle -> oready0=1; next cycle owen3=1, oa3=5, owdata3=0xDEADBEEF.
REQ-039 Contention: both ivalid held high for 4 cycles after reset, with addresses 1 and 2 -> grants 0,1,0,1; owen3 high for 4 consecutive cycles with oa3=1,2,1,2.
REQ-040 x0 write: ivalid1=1, ia1=0 -> oready1=1; owen3 stays 0 and oa3/owdata3 are unchanged.
REQ-041 Scoreboard (macro defined): ireserve_a=7; then irs1=7 -> ohazard=1; a port-1 transfer to 7 -> obusy[7]=0 after the edge; same-cycle reserve 7 plus transfer to 7 -> obusy[7]=1.
REQ-042 Reset mid-write: irst asserted in the cycle after a transfer -> owen3=0 immediately; obusy=0; the first contention after release grants port 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Two requesters (0: pipeline writeback, 1: long-latency unit) share one
// register-file write port. Contention is resolved round-robin, and the write
// stage is registered with one cycle of latency. Writes to register 0 are
// accepted but never reach the register file.
//
// Optional feature: define RF_ARB_SCOREBOARD_EN to build the busy-register
// scoreboard (reserve on issue, clear on writeback, hazard lookup for two
// source operands). Without the macro obusy and ohazard are tied to 0 and the
// reserve/source inputs are ignored; arbitration is identical in both builds.
module regfile_wr_arbiter #(
    parameter int unsigned MP_DATA_WIDTH = 32,
    parameter int unsigned MP_ADDR_WIDTH = 5
) (
    input  logic                            iclk,
    input  logic                            irst,

    // Requester 0: pipeline writeback
    input  logic                            ivalid0,
    input  logic [MP_ADDR_WIDTH-1:0]        ia0,
    input  logic [MP_DATA_WIDTH-1:0]        iwdata0,
    output logic                            oready0,

    // Requester 1: long-latency unit
    input  logic                            ivalid1,
    input  logic [MP_ADDR_WIDTH-1:0]        ia1,
    input  logic [MP_DATA_WIDTH-1:0]        iwdata1,
    output logic                            oready1,

    // Register-file write port
    output logic                            owen3,
    output logic [MP_ADDR_WIDTH-1:0]        oa3,
    output logic [MP_DATA_WIDTH-1:0]        owdata3,

    // Scoreboard
    input  logic                            ireserve,
    input  logic [MP_ADDR_WIDTH-1:0]        ireserve_a,
    input  logic [MP_ADDR_WIDTH-1:0]        irs1,
    input  logic [MP_ADDR_WIDTH-1:0]        irs2,
    output logic                            ohazard,
    output logic [(2**MP_ADDR_WIDTH)-1:0]   obusy
);

    localparam int unsigned NumRegs = 2 ** MP_ADDR_WIDTH;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------

    // rlast_q holds the port granted on the most recent transfer; 1 after reset
    // so that port 0 wins the first contention.
    logic                     rlast_q;
    logic                     rlast_d;

    logic                     gnt0;
    logic                     gnt1;
    logic                     xfer;
    logic [MP_ADDR_WIDTH-1:0] xfer_a;
    logic [MP_DATA_WIDTH-1:0] xfer_data;

    // Round-robin grant: a lone requester always wins, under contention the
    // port that did not win the last transfer wins.
    always_comb begin
        gnt0      = ivalid0 & (~ivalid1 | rlast_q);
        gnt1      = ivalid1 & (~ivalid0 | ~rlast_q);
        xfer      = gnt0 | gnt1;
        xfer_a    = gnt1 ? ia1 : ia0;
        xfer_data = gnt1 ? iwdata1 : iwdata0;
    end

    assign oready0 = gnt0;
    assign oready1 = gnt1;

    // Last-grant pointer moves only when a transfer actually happens.
    always_comb begin
        rlast_d = rlast_q;
        if (gnt0) begin
            rlast_d = 1'b0;
        end else if (gnt1) begin
            rlast_d = 1'b1;
        end
    end

    // Last-grant register.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            rlast_q <= 1'b1;
        end else begin
            rlast_q <= rlast_d;
        end
    end

    // ------------------------------------------------------------------------
    // Registered write stage
    // ------------------------------------------------------------------------

    logic                     wen_q;
    logic                     wen_d;
    logic [MP_ADDR_WIDTH-1:0] wa_q;
    logic [MP_ADDR_WIDTH-1:0] wa_d;
    logic [MP_DATA_WIDTH-1:0] wdata_q;
    logic [MP_DATA_WIDTH-1:0] wdata_d;

    // A transfer to register 0 is consumed silently: no enable, and address
    // and data keep presenting the last real write.
    always_comb begin
        wen_d   = xfer && (xfer_a != '0);
        wa_d    = wa_q;
        wdata_d = wdata_q;
        if (wen_d) begin
            wa_d    = xfer_a;
            wdata_d = xfer_data;
        end
    end

    // Write-stage registers; reset discards a write not yet presented.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            wen_q   <= 1'b0;
            wa_q    <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
        end
    end

    assign owen3   = wen_q;
    assign oa3     = wa_q;
    assign owdata3 = wdata_q;

    // ------------------------------------------------------------------------
    // Busy-register scoreboard
    // ------------------------------------------------------------------------

`ifdef RF_ARB_SCOREBOARD_EN

    logic [NumRegs-1:0] busy_q;
    logic [NumRegs-1:0] busy_d;
    logic [NumRegs-1:0] set_mask;
    logic [NumRegs-1:0] clr_mask;

    // Clear on writeback, set on reserve; set is applied last so it wins a
    // same-cycle collision. Register 0 is never busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (ireserve && (ireserve_a != '0)) begin
            set_mask[ireserve_a] = 1'b1;
        end
        if (xfer) begin
            clr_mask[xfer_a] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Scoreboard bitmap.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign obusy   = busy_q;
    assign ohazard = busy_q[irs1] | busy_q[irs2];

`else

    // Scoreboard not built: inputs are deliberately left unused.
    logic unused_sb;
    assign unused_sb = ^{ireserve, ireserve_a, irs1, irs2};

    assign obusy   = '0;
    assign ohazard = 1'b0;

`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: the driver pushes expected writes
// derived from hand-computed grants, a monitor pops and compares them on owen3.
module tb_regfile_wr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          ivalid0 = 1'b0;
    logic [AW-1:0] ia0 = '0;
    logic [DW-1:0] iwdata0 = '0;
    logic          oready0;
    logic          ivalid1 = 1'b0;
    logic [AW-1:0] ia1 = '0;
    logic [DW-1:0] iwdata1 = '0;
    logic          oready1;
    logic          owen3;
    logic [AW-1:0] oa3;
    logic [DW-1:0] owdata3;
    logic          ireserve = 1'b0;
    logic [AW-1:0] ireserve_a = '0;
    logic [AW-1:0] irs1 = '0;
    logic [AW-1:0] irs2 = '0;
    logic          ohazard;
    logic [31:0]   obusy;

    regfile_wr_arbiter #(
        .MP_DATA_WIDTH(DW),
        .MP_ADDR_WIDTH(AW)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .ivalid0   (ivalid0),
        .ia0       (ia0),
        .iwdata0   (iwdata0),
        .oready0   (oready0),
        .ivalid1   (ivalid1),
        .ia1       (ia1),
        .iwdata1   (iwdata1),
        .oready1   (oready1),
        .owen3     (owen3),
        .oa3       (oa3),
        .owdata3   (owdata3),
        .ireserve  (ireserve),
        .ireserve_a(ireserve_a),
        .irs1      (irs1),
        .irs2      (irs2),
        .ohazard   (ohazard),
        .obusy     (obusy)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;

    always @(posedge iclk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: a write pushed in cycle c must appear on the write port in c+1;
    // otherwise owen3 is low and address/data hold their last value.
    always @(negedge iclk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("owen3_write", {63'd0, owen3}, 64'd1);
            chk("oa3", {59'd0, oa3}, {59'd0, exp_q[0].a});
            chk("owdata3", {32'd0, owdata3}, {32'd0, exp_q[0].d});
            last_a = exp_q[0].a;
            last_d = exp_q[0].d;
            void'(exp_q.pop_front());
        end else begin
            chk("owen3_idle", {63'd0, owen3}, 64'd0);
            chk("oa3_hold", {59'd0, oa3}, {59'd0, last_a});
            chk("owdata3_hold", {32'd0, owdata3}, {32'd0, last_d});
        end
`ifndef RF_ARB_SCOREBOARD_EN
        chk("obusy_tied", {32'd0, obusy}, 64'd0);
        chk("ohazard_tied", {63'd0, ohazard}, 64'd0);
`endif
    end

    // Drive one cycle starting at posedge+1, check grants, push the expected
    // write, and return at the next posedge+1 with requests dropped.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic e0, input logic e1,
                        input logic res = 1'b0, input logic [AW-1:0] ra = '0);
        ivalid0 = v0; ia0 = a0; iwdata0 = d0;
        ivalid1 = v1; ia1 = a1; iwdata1 = d1;
        ireserve = res; ireserve_a = ra;
        @(negedge iclk);
        chk("oready0", {63'd0, oready0}, {63'd0, e0});
        chk("oready1", {63'd0, oready1}, {63'd0, e1});
        if (e0 && a0 != '0) exp_q.push_back('{cyc: cyc, a: a0, d: d0});
        if (e1 && a1 != '0) exp_q.push_back('{cyc: cyc, a: a1, d: d1});
        @(posedge iclk);
        #1;
        ivalid0 = 1'b0; ivalid1 = 1'b0; ireserve = 1'b0;
    endtask

    // Short reset pulse starting and ending at posedge+1.
    task automatic reset_pulse();
        irst = 1'b1;
        exp_q.delete();
        last_a = '0;
        last_d = '0;
        @(posedge iclk);
        #1;
        irst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge iclk);
        #1;
        // Reset state
        chk("rst_owen3", {63'd0, owen3}, 64'd0);
        chk("rst_oa3", {59'd0, oa3}, 64'd0);
        chk("rst_owdata3", {32'd0, owdata3}, 64'd0);
        chk("rst_obusy", {32'd0, obusy}, 64'd0);
        ivalid0 = 1'b1; ivalid1 = 1'b1;
        #1;
        chk("rst_ready0", {63'd0, oready0}, 64'd1);
        chk("rst_ready1", {63'd0, oready1}, 64'd0);
        ivalid0 = 1'b0; ivalid1 = 1'b0;
        @(posedge iclk);
        #1;
        irst = 1'b0;

        // Idle, then single requester
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Contention from reset: 0,1,0,1
        reset_pulse();
        step(1, 1, 32'h1111_0001, 1, 2, 32'h2222_0001, 1, 0);
        step(1, 1, 32'h1111_0002, 1, 2, 32'h2222_0002, 0, 1);
        step(1, 1, 32'h1111_0003, 1, 2, 32'h2222_0003, 1, 0);
        step(1, 1, 32'h1111_0004, 1, 2, 32'h2222_0004, 0, 1);

        // x0 write accepted but not written; rlast now 1
        step(0, 0, 0, 1, 0, 32'hBAD0_0000, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Lone port 1, then contention alternates starting with port 0
        step(0, 0, 0, 1, 9, 32'h9999_9999, 0, 1);
        step(1, 3, 32'h3333_3333, 1, 4, 32'h4444_4444, 1, 0);
        step(1, 3, 32'h3333_3334, 1, 4, 32'h4444_4445, 0, 1);
        step(1, 31, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        irs1 = 7; irs2 = 0;
        #1;
`ifdef RF_ARB_SCOREBOARD_EN
        chk("sb_busy7_set", {63'd0, obusy[7]}, 64'd1);
        chk("sb_hazard_rs1", {63'd0, ohazard}, 64'd1);
        irs1 = 3; irs2 = 7;
        #1;
        chk("sb_hazard_rs2", {63'd0, ohazard}, 64'd1);
        irs2 = 0;
        #1;
        chk("sb_no_hazard", {63'd0, ohazard}, 64'd0);
`else
        chk("nosb_busy", {32'd0, obusy}, 64'd0);
        chk("nosb_hazard", {63'd0, ohazard}, 64'd0);
`endif
        irs1 = 0;
        step(0, 0, 0, 1, 7, 32'h7777_0001, 0, 1);
`ifdef RF_ARB_SCOREBOARD_EN
        chk("sb_busy7_clear", {63'd0, obusy[7]}, 64'd0);
`endif
        step(1, 7, 32'h7777_0002, 0, 0, 0, 1, 0, 1, 7);
`ifdef RF_ARB_SCOREBOARD_EN
        chk("sb_set_wins", {32'd0, obusy}, 64'h80);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
`ifdef RF_ARB_SCOREBOARD_EN
        chk("sb_x0_never_busy", {32'd0, obusy}, 64'h80);
`endif

        // Reset mid-write: transfer registered, then reset right after the edge
        step(1, 6, 32'h6666_6666, 0, 0, 0, 1, 0);
        irst = 1'b1;
        exp_q.delete();
        last_a = '0;
        last_d = '0;
        #1;
        chk("mid_rst_owen3", {63'd0, owen3}, 64'd0);
        chk("mid_rst_oa3", {59'd0, oa3}, 64'd0);
        chk("mid_rst_owdata3", {32'd0, owdata3}, 64'd0);
        chk("mid_rst_obusy", {32'd0, obusy}, 64'd0);
        ivalid0 = 1'b1; ivalid1 = 1'b1;
        @(negedge iclk);
        chk("mid_rst_ready0", {63'd0, oready0}, 64'd1);
        chk("mid_rst_ready1", {63'd0, oready1}, 64'd0);
        @(posedge iclk);
        #1;
        ivalid0 = 1'b0; ivalid1 = 1'b0;
        irst = 1'b0;
        step(1, 4, 32'h4040_4040, 1, 8, 32'h8080_8080, 1, 0);
        step(1, 4, 32'h4040_4041, 1, 8, 32'h8080_8081, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
